pcs_10g_enc_tx_param: RTL and testbench

// - Next-gen 10GBASE-R TX encoder: accepts XGMII (32b DDR-folded or 64b) words, builds
//   64b/66b blocks and runs the IEEE 802.3 Cl.49 TX state machine (error/fault substitution).
// - Sits between the XGMII MAC interface and the TX scrambler/gearbox; backpressure from gearbox.

---
 rtl/pcs_10g_pkg.sv | 67 ++++++
 rtl/pcs_10g_enc_tx_param_blk_enc.sv | 132 +++++++++++++
 rtl/pcs_10g_enc_tx_param.sv | 122 ++++++++++++
 tb/tb_pcs_10g_enc_tx_param.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_10g_pkg.sv
// 10GBASE-R TX encoder shared definitions:
// XGMII characters, 64b/66b block types, FSM states.
package pcs_10g_pkg;

  localparam logic [7:0] XG_IDLE  = 8'h07;
  localparam logic [7:0] XG_START = 8'hFB;
  localparam logic [7:0] XG_TERM  = 8'hFD;
  localparam logic [7:0] XG_ERR   = 8'hFE;
  localparam logic [7:0] XG_SEQ   = 8'h9C;

  localparam logic [6:0] C7_IDLE = 7'h00;
  localparam logic [6:0] C7_ERR  = 7'h1E;
  localparam logic [3:0] O_SEQ   = 4'h0;

  localparam logic [7:0] BT_C     = 8'h1E;
  localparam logic [7:0] BT_O0    = 8'h4B;
  localparam logic [7:0] BT_O4    = 8'h2D;
  localparam logic [7:0] BT_C_S4  = 8'h33;
  localparam logic [7:0] BT_O0_S4 = 8'h66;
  localparam logic [7:0] BT_S0    = 8'h78;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [65:0] LBLOCK_T = {
    28'h0, O_SEQ, 8'h01, 8'h00, 8'h00,
    BT_O0, SYNC_CTRL
  };

  localparam logic [65:0] EBLOCK_T = {
    {8{C7_ERR}}, BT_C, SYNC_CTRL
  };

  typedef enum logic [2:0] {
    TX_INIT,
    TX_C,
    TX_D,
    TX_T,
    TX_E
  } tx_state_e;

  typedef enum logic [2:0] {
    CLS_C,
    CLS_S,
    CLS_T,
    CLS_D,
    CLS_E
  } blk_cls_e;

  function automatic logic [7:0] t_type(
    input logic [2:0] k
  );
    logic [7:0] t;
    case (k)
      3'd0: t = 8'h87;
      3'd1: t = 8'h99;
      3'd2: t = 8'hAA;
      3'd3: t = 8'hB4;
      3'd4: t = 8'hCC;
      3'd5: t = 8'hD2;
      3'd6: t = 8'hE1;
      3'd7: t = 8'hFF;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pcs_10g_enc_tx_param_blk_enc.sv
// Combinational 64b/66b block encoder:
// 8-lane XGMII word -> block class + 66b block.
module pcs_64b66b_block_enc
  import pcs_10g_pkg::*;
(
  input  logic [63:0] d,
  input  logic [7:0]  c,
  output blk_cls_e    cls,
  output logic [65:0] blk
);

  logic [7:0][7:0] ln;
  logic [7:0][6:0] cc;
  logic [7:0]      is_i;
  logic [7:0]      is_ie;
  logic [7:0]      t_hit;
  logic [2:0]      t_k;
  logic [55:0]     t_mask;
  logic            all_ie;
  logic            lo_ie;
  logic            hi_ie;
  logic            o0;
  logic            o4;
  logic            s0;
  logic            s4;
  logic [55:0]     pay;
  logic [7:0]      btype;
  logic [1:0]      hdr;

  assign ln = d;

  // per-lane idle/error detect and 7b code map
  always_comb begin
    is_i  = '0;
    is_ie = '0;
    cc    = '0;
    for (int k = 0; k < 8; k++) begin
      is_i[k]  = c[k] && (ln[k] == XG_IDLE);
      is_ie[k] = is_i[k] ||
                 (c[k] && (ln[k] == XG_ERR));
      cc[k]    = (ln[k] == XG_ERR) ?
                 C7_ERR : C7_IDLE;
    end
  end

  // locate /T/: data below, idles above
  always_comb begin
    t_hit = '0;
    t_k   = '0;
    for (int k = 0; k < 8; k++) begin
      t_hit[k] = c[k] && (ln[k] == XG_TERM);
      for (int j = 0; j < 8; j++) begin
        if (j < k && c[j])
          t_hit[k] = 1'b0;
        if (j > k && !is_i[j])
          t_hit[k] = 1'b0;
      end
      if (t_hit[k])
        t_k = 3'(k);
    end
  end

  assign all_ie = &is_ie;
  assign lo_ie  = &is_ie[3:0];
  assign hi_ie  = &is_ie[7:4];

  assign o0 = c[0] && (ln[0] == XG_SEQ) &&
              (c[3:1] == 3'b000);
  assign o4 = c[4] && (ln[4] == XG_SEQ) &&
              (c[7:5] == 3'b000);
  assign s0 = c[0] && (ln[0] == XG_START) &&
              (c[7:1] == 7'h00);
  assign s4 = c[4] && (ln[4] == XG_START) &&
              (c[7:5] == 3'b000);

  // keep only the data bytes ahead of /T/
  assign t_mask = ~({56{1'b1}} << {t_k, 3'b000});

  // classify and build the block
  always_comb begin
    cls   = CLS_E;
    hdr   = SYNC_CTRL;
    btype = BT_C;
    pay   = '0;
    unique case (1'b1)
      all_ie: begin
        cls = CLS_C;
        pay = cc;
      end
      o0 && hi_ie: begin
        cls   = CLS_C;
        btype = BT_O0;
        pay   = {cc[7:4], O_SEQ, d[31:8]};
      end
      lo_ie && o4: begin
        cls   = CLS_C;
        btype = BT_O4;
        pay   = {d[63:40], O_SEQ, cc[3:0]};
      end
      lo_ie && s4: begin
        cls   = CLS_S;
        btype = BT_C_S4;
        pay   = {d[63:40], 4'h0, cc[3:0]};
      end
      o0 && s4: begin
        cls   = CLS_S;
        btype = BT_O0_S4;
        pay   = {d[63:40], 4'h0, O_SEQ,
                 d[31:8]};
      end
      s0: begin
        cls   = CLS_S;
        btype = BT_S0;
        pay   = d[63:8];
      end
      |t_hit: begin
        cls   = CLS_T;
        btype = t_type(t_k);
        pay   = d[55:0] & t_mask;
      end
      c == 8'h00: begin
        cls   = CLS_D;
        hdr   = SYNC_DATA;
        btype = d[7:0];
        pay   = d[63:8];
      end
      default: cls = CLS_E;
    endcase
    blk = {pay, btype, hdr};
  end

endmodule

// File: rtl/pcs_10g_enc_tx_param.sv
// 10GBASE-R TX encoder top: XGMII 32/64b in,
// Cl.49 TX FSM, registered 66b block out.
module pcs_10g_enc_tx_param
  import pcs_10g_pkg::*;
#(
  parameter  int XGMII_DATA_W = 64,
  localparam int XGMII_CTRL_W = XGMII_DATA_W / 8,
  localparam int BLOCK_W      = 66
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    xgmii_valid_i,
  input  logic [XGMII_DATA_W-1:0] xgmii_txd_i,
  input  logic [XGMII_CTRL_W-1:0] xgmii_txc_i,
  output logic                    xgmii_ready_o,
  output logic                    block_valid_o,
  output logic [BLOCK_W-1:0]      block_o,
  input  logic                    block_ready_i
);

  logic        acc;
  logic        word_done;
  logic [63:0] word_d;
  logic [7:0]  word_c;
  blk_cls_e    cls;
  logic [65:0] enc_blk;
  logic [65:0] nxt_blk;
  tx_state_e   state;
  tx_state_e   nxt;

  assign xgmii_ready_o = ~reset &
    (~block_valid_o | block_ready_i);
  assign acc = xgmii_valid_i & xgmii_ready_o;

  if (XGMII_DATA_W == 64) begin : g_w64
    assign word_d    = xgmii_txd_i;
    assign word_c    = xgmii_txc_i;
    assign word_done = acc;
  end else if (XGMII_DATA_W == 32) begin : g_w32
    logic        phase;
    logic [31:0] lo_d;
    logic [3:0]  lo_c;

    // hold lanes 0-3 until lanes 4-7 arrive
    always_ff @(posedge clk) begin
      if (reset) begin
        phase <= 1'b0;
        lo_d  <= '0;
        lo_c  <= '0;
      end else if (acc) begin
        phase <= ~phase;
        if (!phase) begin
          lo_d <= xgmii_txd_i;
          lo_c <= xgmii_txc_i;
        end
      end
    end

    assign word_d    = {xgmii_txd_i, lo_d};
    assign word_c    = {xgmii_txc_i, lo_c};
    assign word_done = acc & phase;
  end else begin : g_bad
    $error("XGMII_DATA_W must be 32 or 64");
  end

  pcs_64b66b_block_enc u_enc (
    .d   (word_d),
    .c   (word_c),
    .cls (cls),
    .blk (enc_blk)
  );

  // Cl.49 TX transition on a completed block
  always_comb begin
    nxt = TX_E;
    unique case (state)
      TX_INIT, TX_C, TX_T: begin
        if (cls == CLS_C)      nxt = TX_C;
        else if (cls == CLS_S) nxt = TX_D;
        else                   nxt = TX_E;
      end
      TX_D: begin
        if (cls == CLS_D)      nxt = TX_D;
        else if (cls == CLS_T) nxt = TX_T;
        else                   nxt = TX_E;
      end
      TX_E: begin
        if (cls == CLS_D)      nxt = TX_D;
        else if (cls == CLS_C) nxt = TX_C;
        else if (cls == CLS_T) nxt = TX_T;
        else                   nxt = TX_E;
      end
      default: nxt = TX_E;
    endcase
  end

  // substitute error/fault blocks by target
  always_comb begin
    nxt_blk = enc_blk;
    unique case (nxt)
      TX_INIT: nxt_blk = LBLOCK_T;
      TX_E:    nxt_blk = EBLOCK_T;
      default: nxt_blk = enc_blk;
    endcase
  end

  // output register, state and handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= TX_INIT;
      block_valid_o <= 1'b0;
      block_o       <= LBLOCK_T;
    end else if (word_done) begin
      state         <= nxt;
      block_valid_o <= 1'b1;
      block_o       <= nxt_blk;
    end else if (block_ready_i) begin
      block_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pcs_10g_enc_tx_param.sv
// Directed bench for pcs_10g_enc_tx_param:
// 64b and 32b instances, hand-built blocks.
module tb_pcs_10g_enc_tx_param;

  localparam logic [65:0] LBLK =
    {28'h0, 4'h0, 24'h010000, 8'h4B, 2'b10};
  localparam logic [65:0] EBLK =
    {{8{7'h1E}}, 8'h1E, 2'b10};
  localparam logic [65:0] IBLK = 66'h7A;
  localparam logic [65:0] S0BLK =
    {56'hD5555555555555, 8'h78, 2'b10};
  localparam logic [65:0] T0BLK =
    {56'h0, 8'h87, 2'b10};

  localparam logic [63:0] W_IDLE = 64'h0707070707070707;
  localparam logic [63:0] W_S0   = 64'hD5555555555555FB;
  localparam logic [63:0] W_D1   = 64'h0123456789ABCDEF;
  localparam logic [63:0] W_D2   = 64'hFEDCBA9876543210;
  localparam logic [63:0] W_T3   = 64'h07070707FD332211;
  localparam logic [63:0] W_T0   = 64'h07070707070707FD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v64 = 1'b0;
  logic [63:0] d64 = '0;
  logic [7:0]  c64 = '0;
  logic        xr64;
  logic        vo64;
  logic [65:0] blk64;
  logic        r64 = 1'b1;
  logic        v32 = 1'b0;
  logic [31:0] d32 = '0;
  logic [3:0]  c32 = '0;
  logic        xr32;
  logic        vo32;
  logic [65:0] blk32;
  logic        r32 = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcs_10g_enc_tx_param #(.XGMII_DATA_W(64)) dut64 (
    .clk           (clk),
    .reset         (reset),
    .xgmii_valid_i (v64),
    .xgmii_txd_i   (d64),
    .xgmii_txc_i   (c64),
    .xgmii_ready_o (xr64),
    .block_valid_o (vo64),
    .block_o       (blk64),
    .block_ready_i (r64)
  );

  pcs_10g_enc_tx_param #(.XGMII_DATA_W(32)) dut32 (
    .clk           (clk),
    .reset         (reset),
    .xgmii_valid_i (v32),
    .xgmii_txd_i   (d32),
    .xgmii_txc_i   (c32),
    .xgmii_ready_o (xr32),
    .block_valid_o (vo32),
    .block_o       (blk32),
    .block_ready_i (r32)
  );

  task automatic send64(input logic [63:0] d,
                        input logic [7:0] c);
    @(negedge clk);
    v64 = 1'b1; d64 = d; c64 = c;
    @(posedge clk); #1;
    v64 = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d,
                        input logic [3:0] c);
    @(negedge clk);
    v32 = 1'b1; d32 = d; c32 = c;
    @(posedge clk); #1;
    v32 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (vo64 !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid64: got %b want 0", vo64);
    end
    checks++;
    if (blk64 !== LBLK) begin
      errors++;
      $display("FAIL rst_blk64: got %h want %h", blk64, LBLK);
    end
    checks++;
    if (vo32 !== 1'b0 || blk32 !== LBLK) begin
      errors++;
      $display("FAIL rst_32: got %b/%h want 0/%h",
               vo32, blk32, LBLK);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (xr64 !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready64: got %b want 1", xr64);
    end
  endtask

  task automatic test_idle64;
    send64(W_IDLE, 8'hFF);
    checks++;
    if (vo64 !== 1'b1 || blk64 !== IBLK) begin
      errors++;
      $display("FAIL idle_blk: got %b/%h want 1/%h",
               vo64, blk64, IBLK);
    end
    @(posedge clk); #1;
    checks++;
    if (vo64 !== 1'b0) begin
      errors++;
      $display("FAIL idle_drop: got %b want 0", vo64);
    end
  endtask

  task automatic test_frame64;
    logic [63:0] wd[5];
    logic [7:0]  wc[5];
    logic [65:0] we[5];
    wd = '{W_S0, W_D1, W_D2, W_T3, W_IDLE};
    wc = '{8'h01, 8'h00, 8'h00, 8'hF8, 8'hFF};
    we = '{S0BLK, {W_D1, 2'b01}, {W_D2, 2'b01},
           {32'h0, 24'h332211, 8'hB4, 2'b10}, IBLK};
    for (int i = 0; i < 5; i++) begin
      send64(wd[i], wc[i]);
      checks++;
      if (vo64 !== 1'b1 || blk64 !== we[i]) begin
        errors++;
        $display("FAIL frame64[%0d]: got %b/%h want 1/%h",
                 i, vo64, blk64, we[i]);
      end
    end
  endtask

  task automatic test_term_bounds;
    logic [63:0] wd[5];
    logic [7:0]  wc[5];
    logic [65:0] we[5];
    wd = '{W_S0, 64'hFD66554433221100, W_S0, W_T0,
           64'h070707070100009C};
    wc = '{8'h01, 8'h80, 8'h01, 8'hFF, 8'hF1};
    we = '{S0BLK, {56'h66554433221100, 8'hFF, 2'b10},
           S0BLK, T0BLK, LBLK};
    for (int i = 0; i < 5; i++) begin
      send64(wd[i], wc[i]);
      checks++;
      if (blk64 !== we[i]) begin
        errors++;
        $display("FAIL tbound[%0d]: got %h want %h",
                 i, blk64, we[i]);
      end
    end
  endtask

  task automatic test_error64;
    logic [63:0] wd[7];
    logic [7:0]  wc[7];
    logic [65:0] we[7];
    wd = '{W_D1, W_IDLE, W_S0, 64'h1111111111122222,
           W_D1, W_T0, W_IDLE};
    wc = '{8'h00, 8'hFF, 8'h01, 8'h04,
           8'h00, 8'hFF, 8'hFF};
    we = '{EBLK, IBLK, S0BLK, EBLK,
           {W_D1, 2'b01}, T0BLK, IBLK};
    for (int i = 0; i < 7; i++) begin
      send64(wd[i], wc[i]);
      checks++;
      if (blk64 !== we[i]) begin
        errors++;
        $display("FAIL err64[%0d]: got %h want %h",
                 i, blk64, we[i]);
      end
    end
  endtask

  task automatic test_width32;
    logic [31:0] hd[6];
    logic [3:0]  hc[6];
    logic [65:0] we[3];
    hd = '{32'h07070707, 32'h07070707,
           32'h07070707, 32'hCCBBAAFB,
           32'h070707FD, 32'h07070707};
    hc = '{4'hF, 4'hF, 4'hF, 4'h1, 4'hF, 4'hF};
    we = '{IBLK, {24'hCCBBAA, 32'h0, 8'h33, 2'b10},
           T0BLK};
    for (int i = 0; i < 6; i++) begin
      send32(hd[i], hc[i]);
      checks++;
      if (vo32 !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL w32_valid[%0d]: got %b want %b",
                 i, vo32, ((i % 2) == 1));
      end
      if ((i % 2) == 1) begin
        checks++;
        if (blk32 !== we[i/2]) begin
          errors++;
          $display("FAIL w32_blk[%0d]: got %h want %h",
                   i / 2, blk32, we[i/2]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] wd[5];
    logic [7:0]  wc[5];
    logic [65:0] we[5];
    logic [65:0] held;
    logic        acc;
    int          wi;
    int          got;
    wd = '{W_S0, W_D1, W_D2, W_T3, W_IDLE};
    wc = '{8'h01, 8'h00, 8'h00, 8'hF8, 8'hFF};
    we = '{S0BLK, {W_D1, 2'b01}, {W_D2, 2'b01},
           {32'h0, 24'h332211, 8'hB4, 2'b10}, IBLK};
    wi = 0;
    got = 0;
    held = '0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (wi < 5) begin
        v64 = 1'b1; d64 = wd[wi]; c64 = wc[wi];
      end else begin
        v64 = 1'b0;
      end
      r64 = !(cyc >= 2 && cyc < 7);
      #1;
      if (cyc == 2) held = blk64;
      if (cyc >= 2 && cyc < 7) begin
        checks++;
        if (xr64 !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready[%0d]: got %b want 0",
                   cyc, xr64);
        end
        checks++;
        if (vo64 !== 1'b1 || blk64 !== held) begin
          errors++;
          $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h",
                   cyc, vo64, blk64, held);
        end
      end
      if (vo64 && r64 && got < 5) begin
        checks++;
        if (blk64 !== we[got]) begin
          errors++;
          $display("FAIL bp_seq[%0d]: got %h want %h",
                   got, blk64, we[got]);
        end
        got++;
      end
      acc = v64 && xr64;
      @(posedge clk);
      if (acc) wi++;
      if (got == 5) break;
    end
    #1;
    v64 = 1'b0;
    r64 = 1'b1;
    checks++;
    if (got != 5 || wi != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d/%0d want 5/5",
               got, wi);
    end
  endtask

  task automatic test_reset_mid;
    send64(W_IDLE, 8'hFF);
    send64(W_S0, 8'h01);
    checks++;
    if (blk64 !== S0BLK) begin
      errors++;
      $display("FAIL rm_s0: got %h want %h", blk64, S0BLK);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (vo64 !== 1'b0 || blk64 !== LBLK) begin
      errors++;
      $display("FAIL rm_rst: got %b/%h want 0/%h",
               vo64, blk64, LBLK);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (xr64 !== 1'b1) begin
      errors++;
      $display("FAIL rm_ready: got %b want 1", xr64);
    end
    send64(W_D1, 8'h00);
    checks++;
    if (vo64 !== 1'b1 || blk64 !== EBLK) begin
      errors++;
      $display("FAIL rm_d: got %b/%h want 1/%h",
               vo64, blk64, EBLK);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle64();
    test_frame64();
    test_term_bounds();
    test_error64();
    test_width32();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
